// File: rtl/stage_mem.sv
// stage_mem: memory stage of a pipeline with a byte-wide RAM port.
// Loads and stores of 1, 2 or 4 bytes run one byte per cycle, little-endian.
// The upstream stages are held with stall_mem until the access completes.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   load, store       access request from execute (load wins if both are set)
//   mem_length        access size in bytes (1, 2, otherwise 4)
//   mem_signed        sign-extend load result
//   mem_write_data    store data
//   write_i, regw_addr_i, regw_data_i   writeback request; regw_data_i is
//                     also the effective address for loads and stores
//   write_o, regw_addr_o, regw_data_o   writeback request to the next stage
//   stall_mem         hold the upstream pipeline
//   ram_addr, ram_rw, ram_wdata, ram_rdata   byte RAM port (1-cycle read)
//
// state  | meaning
// IDLE   | no access in flight; a new request already drives byte 0
// ACCESS | driving byte k; loads capture byte k-1 from the RAM
// WAIT   | load only: capture the last byte
// DONE   | result presented to writeback, stall released
module stage_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  mem_length,
    input  logic        mem_signed,
    input  logic [31:0] mem_write_data,
    input  logic        write_i,
    input  logic [4:0]  regw_addr_i,
    input  logic [31:0] regw_data_i,
    output logic        write_o,
    output logic [4:0]  regw_addr_o,
    output logic [31:0] regw_data_o,
    output logic        stall_mem,
    output logic [31:0] ram_addr,
    output logic        ram_rw,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] buf_q, buf_d;

    logic        active;
    logic        is_store;
    logic [1:0]  last_k;
    logic [1:0]  k_cur;
    logic [1:0]  cap_idx;
    logic [31:0] load_ext;

    always_comb begin
        active   = load | store;
        is_store = store & ~load;
        case (mem_length)
            3'd1:    last_k = 2'd0;
            3'd2:    last_k = 2'd1;
            default: last_k = 2'd3;
        endcase
        // IDLE behaves as ACCESS with k=0 so a request costs no extra cycle.
        k_cur   = (state_q == IDLE) ? 2'd0 : k_q;
        cap_idx = k_q - 2'd1;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                k_d = 2'd0;
                if (active) begin
                    if (last_k == 2'd0) begin
                        state_d = is_store ? DONE : WAIT;
                    end else begin
                        state_d = ACCESS;
                        k_d     = 2'd1;
                    end
                end
            end
            ACCESS: begin
                // Read data lags its address by a cycle: this cycle returns byte k-1.
                if (load && k_q != 2'd0) begin
                    buf_d[{cap_idx, 3'b000} +: 8] = ram_rdata;
                end
                if (k_q == last_k) begin
                    state_d = is_store ? DONE : WAIT;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            WAIT: begin
                buf_d[{last_k, 3'b000} +: 8] = ram_rdata;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                k_d     = 2'd0;
            end
            default: begin
                state_d = IDLE;
                k_d     = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        case (last_k)
            2'd0:    load_ext = {{24{mem_signed & buf_q[7]}}, buf_q[7:0]};
            2'd1:    load_ext = {{16{mem_signed & buf_q[15]}}, buf_q[15:0]};
            default: load_ext = buf_q;
        endcase
    end

    always_comb begin
        write_o     = 1'b0;
        regw_addr_o = 5'd0;
        regw_data_o = 32'd0;
        stall_mem   = 1'b0;
        ram_addr    = 32'd0;
        ram_rw      = 1'b0;
        ram_wdata   = 8'd0;
        if (!reset) begin
            write_o     = write_i;
            regw_addr_o = regw_addr_i;
            regw_data_o = (state_q == DONE && load) ? load_ext : regw_data_i;
            stall_mem   = active && (state_q != DONE);
            ram_addr    = regw_data_i + {30'd0, k_cur};
            ram_rw      = is_store && (state_q == IDLE || state_q == ACCESS);
            ram_wdata   = mem_write_data[{k_cur, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

    logic        clk;
    logic        reset;
    logic        load;
    logic        store;
    logic [2:0]  mem_length;
    logic        mem_signed;
    logic [31:0] mem_write_data;
    logic        write_i;
    logic [4:0]  regw_addr_i;
    logic [31:0] regw_data_i;
    logic        write_o;
    logic [4:0]  regw_addr_o;
    logic [31:0] regw_data_o;
    logic        stall_mem;
    logic [31:0] ram_addr;
    logic        ram_rw;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    stage_mem dut (
        .clk(clk), .reset(reset), .load(load), .store(store),
        .mem_length(mem_length), .mem_signed(mem_signed),
        .mem_write_data(mem_write_data), .write_i(write_i),
        .regw_addr_i(regw_addr_i), .regw_data_i(regw_data_i),
        .write_o(write_o), .regw_addr_o(regw_addr_o), .regw_data_o(regw_data_o),
        .stall_mem(stall_mem), .ram_addr(ram_addr), .ram_rw(ram_rw),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        w;
        logic [4:0]  a;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_log[$];
    logic [31:0] rd_log[$];
    logic [7:0]  mem[logic [31:0]];
    logic        req_valid;
    int          checks;
    int          errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte RAM with one-cycle read latency; logs every write and load address.
    always @(posedge clk) begin
        if (!reset && ram_rw) begin
            mem[ram_addr] = ram_wdata;
            wr_log.push_back('{addr: ram_addr, data: ram_wdata});
        end
        if (!reset && stall_mem && load && !ram_rw)
            rd_log.push_back(ram_addr);
        ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;
    end

    // Monitor: the writeback result is valid whenever a request is present and not stalled.
    always @(negedge clk) begin
        if (!reset && req_valid && !stall_mem) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", regw_data_o, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, " data"}, regw_data_o, e.data);
                check({e.name, " write_o"}, {31'd0, write_o}, {31'd0, e.w});
                check({e.name, " regw_addr_o"}, {27'd0, regw_addr_o}, {27'd0, e.a});
            end
        end
    end

    task automatic do_op(input string name, input bit ld, input bit st, input logic [2:0] len,
                         input bit sgn, input logic [31:0] wd, input bit wi, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] exp_data,
                         input int exp_stall, input bit rel_reset);
        int  n;
        bit  done;
        @(posedge clk);
        #1;
        if (rel_reset) reset = 1'b0;
        load = ld; store = st; mem_length = len; mem_signed = sgn;
        mem_write_data = wd; write_i = wi; regw_addr_i = rd; regw_data_i = addr;
        wr_log.delete();
        rd_log.delete();
        exp_q.push_back('{name: name, data: exp_data, w: wi, a: rd});
        req_valid = 1'b1;
        n = 0;
        done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0 && exp_stall > 0) check({name, " first addr"}, ram_addr, addr);
            if (!stall_mem) begin
                done = 1;
                break;
            end
            n++;
        end
        check({name, " stall cycles"}, n, exp_stall);
        if (!done) $display("FAIL %s: stall never released", name);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        load = 1'b0;
        store = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        req_valid = 1'b0;
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem[32'h200] = 8'h80;
        mem[32'h210] = 8'h34; mem[32'h211] = 8'h92;

        // Reset with live inputs: every output forced to 0.
        reset = 1'b1;
        load = 1'b1; store = 1'b0; mem_length = 3'd4; mem_signed = 1'b0;
        mem_write_data = 32'hDEADBEEF; write_i = 1'b1; regw_addr_i = 5'd9; regw_data_i = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst write_o", {31'd0, write_o}, 32'd0);
        check("rst regw_data_o", regw_data_o, 32'd0);
        check("rst stall_mem", {31'd0, stall_mem}, 32'd0);
        check("rst ram_addr", ram_addr, 32'd0);
        check("rst ram_rw", {31'd0, ram_rw}, 32'd0);
        load = 1'b0;

        do_op("ADD", 0, 0, 3'd4, 0, 32'h0, 1, 5'd7, 32'h55, 32'h55, 0, 1);

        do_op("LW", 1, 0, 3'd4, 0, 32'h0, 1, 5'd3, 32'h100, 32'h12345678, 5, 0);
        check("LW rd count", rd_log.size(), 5);
        for (int i = 0; i < 4; i++)
            check($sformatf("LW rd addr %0d", i), (rd_log.size() > i) ? rd_log[i] : 32'hx, 32'h100 + i);

        do_op("LB", 1, 0, 3'd1, 1, 32'h0, 1, 5'd4, 32'h200, 32'hFFFFFF80, 2, 0);
        do_op("LBU", 1, 0, 3'd1, 0, 32'h0, 1, 5'd5, 32'h200, 32'h00000080, 2, 0);
        do_op("LH", 1, 0, 3'd2, 1, 32'h0, 1, 5'd6, 32'h210, 32'hFFFF9234, 3, 0);

        do_op("SH", 0, 1, 3'd2, 0, 32'hAABBCCDD, 0, 5'd0, 32'h300, 32'h300, 2, 0);
        check("SH wr count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("SH wr0 addr", wr_log[0].addr, 32'h300);
            check("SH wr0 data", {24'd0, wr_log[0].data}, 32'hDD);
            check("SH wr1 addr", wr_log[1].addr, 32'h301);
            check("SH wr1 data", {24'd0, wr_log[1].data}, 32'hCC);
        end

        do_op("SW wrap", 0, 1, 3'd4, 0, 32'h11223344, 0, 5'd0, 32'hFFFFFFFE, 32'hFFFFFFFE, 4, 0);
        check("SW wr count", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            check("SW wr0 addr", wr_log[0].addr, 32'hFFFFFFFE);
            check("SW wr1 addr", wr_log[1].addr, 32'hFFFFFFFF);
            check("SW wr2 addr", wr_log[2].addr, 32'h00000000);
            check("SW wr3 addr", wr_log[3].addr, 32'h00000001);
            check("SW wr3 data", {24'd0, wr_log[3].data}, 32'h11);
        end
        do_op("LW wrap", 1, 0, 3'd4, 0, 32'h0, 1, 5'd8, 32'hFFFFFFFE, 32'h11223344, 5, 0);

        do_op("SB", 0, 1, 3'd1, 0, 32'h000000A5, 0, 5'd0, 32'h400, 32'h400, 1, 0);
        check("SB wr count", wr_log.size(), 1);
        if (wr_log.size() == 1) check("SB wr data", {24'd0, wr_log[0].data}, 32'hA5);

        do_op("LD+ST", 1, 1, 3'd2, 0, 32'hCAFEF00D, 1, 5'd10, 32'h100, 32'h00005678, 3, 0);
        check("LD+ST wr count", wr_log.size(), 0);

        do_op("LEN3", 1, 0, 3'd3, 0, 32'h0, 1, 5'd11, 32'h100, 32'h12345678, 5, 0);

        // Reset during cycle 2 of a word load, then the load is retried in full.
        @(posedge clk);
        #1;
        load = 1'b1; store = 1'b0; mem_length = 3'd4; mem_signed = 1'b0;
        write_i = 1'b1; regw_addr_i = 5'd12; regw_data_i = 32'h100;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst stall_mem", {31'd0, stall_mem}, 32'd0);
        check("midrst ram_rw", {31'd0, ram_rw}, 32'd0);
        check("midrst regw_data_o", regw_data_o, 32'd0);
        check("midrst write_o", {31'd0, write_o}, 32'd0);
        do_op("LW retry", 1, 0, 3'd4, 0, 32'h0, 1, 5'd12, 32'h100, 32'h12345678, 5, 1);

        repeat (3) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 SHALL have reset: reset, synchronous, active-high.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- load  in  1  load request from execute stage
- store  in  1  store request from execute stage
- mem_length  in  3  access bytes (1, 2 or 4)
- mem_signed  in  1  sign-extend load result
- mem_write_data  in  32  store data
- write_i  in  1  register write enable from execute
- regw_addr_i  in  5  destination register
- regw_data_i  in  32  ALU result; effective address when load/store
- write_o  out  1  register write enable to writeback
- regw_addr_o  out  5  destination register
- regw_data_o  out  32  writeback data
- stall_mem  out  1  hold upstream pipeline
- ram_addr  out  32  byte address to RAM
- ram_rw  out  1  1 = write byte, 0 = read/idle
- ram_wdata  out  8  byte to write
- ram_rdata  in  8  read byte, valid one cycle after its address

Function
REQ-003 SHALL use states IDLE, ACCESS, WAIT, DONE, plus byte counter k (0..3).
REQ-004 Neither load nor store: pass-through, zero latency: write_o=write_i, regw_addr_o=regw_addr_i, regw_data_o=regw_data_i, stall_mem=0, ram_rw=0.
REQ-005 stall_mem SHALL be combinational: 1 when (load|store) and state!=DONE.
REQ-006 Length N: mem_length 1 -> 1, 2 -> 2, any other value -> 4.
REQ-007 Byte k SHALL use address regw_data_i+k, modulo 2^32 (wrap at 0xFFFFFFFF).
REQ-008 Byte order little-endian: byte k <-> bits [8k+7:8k].
REQ-009 Store: IDLE sees store -> ACCESS, k=0; each ACCESS cycle drives ram_addr=addr+k, ram_rw=1, ram_wdata=byte k of mem_write_data; after byte N-1 -> DONE; stall_mem high for exactly N cycles.
REQ-010 Load: each ACCESS cycle drives ram_addr=addr+k, ram_rw=0 and captures ram_rdata as byte k-1 (k>=1); after addr+N-1 -> WAIT; WAIT captures byte N-1 -> DONE; stall_mem high for exactly N+1 cycles.
REQ-011 IDLE with load/store present SHALL already drive byte 0 (IDLE acts as ACCESS k=0); one-byte store goes IDLE->DONE, one-byte load IDLE->WAIT->DONE.
REQ-012 DONE: stall_mem=0, ram_rw=0; load drives regw_data_o = result extended per mem_signed (zero- or sign-extend from bit 8N-1); store drives regw_data_o=regw_data_i; next state IDLE.
REQ-013 write_o=write_i and regw_addr_o=regw_addr_i in every state.
REQ-014 load and store both 1: load served, store ignored.
REQ-015 Upstream inputs SHALL be held stable while stall_mem=1; block need not tolerate changes mid-access.
REQ-016 ram_rw SHALL be 0 in WAIT, DONE, IDLE-without-store and reset.

Reset
REQ-017 Reset SHALL force state IDLE, k=0, load buffer 0 at the clock edge, including mid-access.
REQ-018 While reset=1: write_o=0, regw_addr_o=0, regw_data_o=0, stall_mem=0, ram_addr=0, ram_rw=0, ram_wdata=0.
REQ-019 First cycle after reset SHALL treat inputs as a fresh request from IDLE.

Verification
REQ-020 LW addr 0x100, RAM bytes 0x100..0x103=78 56 34 12 -> ram_addr 100,101,102,103; stall 5 cycles; DONE regw_data_o=0x12345678.
REQ-021 LB signed addr 0x200, byte 0x80 -> stall 2 cycles, 0xFFFFFF80; same with mem_signed=0 -> 0x00000080; LH signed bytes 0x34 0x92 -> 0xFFFF9234.
REQ-022 SH addr 0x300 data 0xAABBCCDD -> two cycles ram_rw=1: (0x300,0xDD),(0x301,0xCC); stall 2 cycles; no byte to 0x302.
REQ-023 SW addr 0xFFFFFFFE -> writes at FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-024 Reset asserted during cycle 2 of LW -> next cycle IDLE, ram_rw=0, stall_mem=0, outputs 0; LW retried after reset takes full 5 stall cycles.
REQ-025 ADD result 0x55, write_i=1, rd=7, load=store=0 -> same-cycle write_o=1, regw_addr_o=7, regw_data_o=0x55, stall_mem=0.
